// File: rtl/fpu_sched_pkg.sv
// fpu_sched_pkg: shared types and constants for the FPU job scheduler.
//   sched_state_e - controller states (IDLE, ISSUE, WAIT, RESP)
//   FPU_OP_*      - opcode values carried in the CMD register low bits
//   DATA_W_DEF / OP_W_DEF - default operand and opcode widths
package fpu_sched_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 4;

  localparam logic [OP_W_DEF-1:0] FPU_OP_ADD = 4'd1;
  localparam logic [OP_W_DEF-1:0] FPU_OP_SUB = 4'd2;
  localparam logic [OP_W_DEF-1:0] FPU_OP_MUL = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin grant.
//   req   [1:0] - request vector
//   last        - index of the requester served most recently
//   grant [1:0] - one-hot grant (zero when nothing is requested)
// A lone requester always wins; on contention the one that was not served
// last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/fpu_job_scheduler.sv
// fpu_job_scheduler: shares one variable-latency FPU between two requesters
// (port 0 host bridge, port 1 on-chip sequencer), one job in flight at a time.
//   clk, reset (sync, active-low)
//   req_valid/req_ready/req_op/req_a/req_b - per-requester job request channel
//   rsp_valid/rsp_ready/rsp_data/rsp_err   - per-requester result channel
//   fpu_start/fpu_op/fpu_a/fpu_b           - job issue to the FPU datapath
//   fpu_done/fpu_result                    - FPU completion
//   busy, grant_id                         - status
// Build option FPU_TIMEOUT_EN: abort a job that sits in WAIT for TIMEOUT
// cycles, returning rsp_err=1 and rsp_data=0. Without it WAIT is unbounded.
//
// state | meaning
// IDLE  | arbitrate, accept one job
// ISSUE | one-cycle fpu_start pulse
// WAIT  | waiting for fpu_done (or timeout)
// RESP  | result held for the granted requester until accepted
module fpu_job_scheduler
  import fpu_sched_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                fpu_start,
  output logic [OP_W-1:0]     fpu_op,
  output logic [DATA_W-1:0]   fpu_a,
  output logic [DATA_W-1:0]   fpu_b,
  input  logic                fpu_done,
  input  logic [DATA_W-1:0]   fpu_result,
  output logic                busy,
  output logic                grant_id
);

  // The wait counter is 8 bits wide, so the abort point must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 256) begin : g_timeout_range
    $error("TIMEOUT must be within 1..256");
  end

  sched_state_e        state_q, state_d;
  logic                last_grant_q;
  logic                grant_id_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic [1:0]          grant;
  logic                winner;
  logic                accept;
  logic                expire;

  rr_arbiter2 u_arb (
    .req   (req_valid),
    .last  (last_grant_q),
    .grant (grant)
  );

  assign winner = grant[1];
  assign accept = (state_q == IDLE) && (grant != 2'b00);

`ifdef FPU_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt;
  logic       rsp_err_q;

  // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state_q != WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign expire = (state_q == WAIT) && (wait_cnt == TO_LAST);

  // A done arriving on the expiry cycle takes priority over the abort.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_err_q <= 1'b0;
    end else if (state_q == WAIT) begin
      if (fpu_done) begin
        rsp_err_q <= 1'b0;
      end else if (expire) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    fpu_start = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (accept) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        fpu_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (fpu_done || expire) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = grant_id_q ? 2'b10 : 2'b01;
        if (rsp_ready[grant_id_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_data_q   <= '0;
    end else begin
      if (accept) begin
        grant_id_q <= winner;
        op_q       <= winner ? req_op[2*OP_W-1:OP_W]     : req_op[OP_W-1:0];
        a_q        <= winner ? req_a[2*DATA_W-1:DATA_W]  : req_a[DATA_W-1:0];
        b_q        <= winner ? req_b[2*DATA_W-1:DATA_W]  : req_b[DATA_W-1:0];
      end
      if (state_q == WAIT) begin
        if (fpu_done) begin
          rsp_data_q <= fpu_result;
        end else if (expire) begin
          rsp_data_q <= '0;
        end
      end
      // Fairness pointer only moves once the result is actually delivered.
      if (state_q == RESP && rsp_ready[grant_id_q]) begin
        last_grant_q <= grant_id_q;
      end
    end
  end

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_id_q;
  assign fpu_op   = op_q;
  assign fpu_a    = a_q;
  assign fpu_b    = b_q;
  assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_fpu_job_scheduler.sv
// tb_fpu_job_scheduler: self-checking bench for fpu_job_scheduler.
// Table of single jobs, directed multi-cycle sequences, then a randomized
// run checked against a transaction-level model. Define FPU_TIMEOUT_EN to
// also exercise the timeout abort (DUT built with TIMEOUT=8).
module tb_fpu_job_scheduler;
  import fpu_sched_pkg::*;

  localparam int DW = 32;
  localparam int OW = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      req_valid, req_ready;
  logic [2*OW-1:0] req_op;
  logic [2*DW-1:0] req_a, req_b;
  logic [1:0]      rsp_valid, rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic            rsp_err, fpu_start, busy, grant_id;
  logic [OW-1:0]   fpu_op;
  logic [DW-1:0]   fpu_a, fpu_b, fpu_result;
  logic            fpu_done, model_done, stray_done;

  assign fpu_done = model_done | stray_done;

  always #5 clk = ~clk;

  fpu_job_scheduler #(.DATA_W(DW), .OP_W(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result),
    .busy(busy), .grant_id(grant_id)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int fpu_lat  = 2;   // 0 = FPU never answers

  logic [OW-1:0] r_op [2];
  logic [DW-1:0] r_a  [2];
  logic [DW-1:0] r_b  [2];

  function automatic logic [DW-1:0] fpu_fn(input logic [OW-1:0] op,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    case (op)
      FPU_OP_ADD: return a + b;
      FPU_OP_SUB: return a - b;
      FPU_OP_MUL: return a * b;
      default:    return a ^ b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_req();
    req_op = {r_op[1], r_op[0]};
    req_a  = {r_a[1], r_a[0]};
    req_b  = {r_b[1], r_b[0]};
  endtask

  // FPU model: answers fpu_lat cycles after the start pulse.
  initial begin
    int pend;
    pend       = 0;
    model_done = 1'b0;
    fpu_result = '0;
    forever begin
      @(posedge clk);
      #1;
      model_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          model_done = 1'b1;
          fpu_result = fpu_fn(fpu_op, fpu_a, fpu_b);
        end
      end
      if (fpu_start && fpu_lat > 0) pend = fpu_lat;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; stray_done = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse_stray();
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
  endtask

  // One job from a lone requester; returns cycles from handshake to rsp_valid.
  task automatic run_job(input int id, input logic [OW-1:0] op,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input int lat, output int rlat,
                         output logic [DW-1:0] data, output logic err);
    int w;
    fpu_lat = lat;
    r_op[id] = op; r_a[id] = a; r_b[id] = b;
    drive_req();
    req_valid[id] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[id] && w < 50) begin
      @(negedge clk); #1; w++;
    end
    if (w == 50) chk("job_req_ready_wait", req_ready[id], 1);
    @(negedge clk);
    req_valid[id] = 1'b0;
    rlat = 1;
    while (rsp_valid == 2'b00 && rlat < 100) begin
      @(negedge clk); rlat++;
    end
    data = rsp_data;
    err  = rsp_err;
    chk("job_rsp_valid", rsp_valid, 2'b01 << id);
    chk("job_grant_id", grant_id, id);
    chk("job_fpu_op", fpu_op, op);
    chk("job_fpu_a", fpu_a, a);
    chk("job_fpu_b", fpu_b, b);
    rsp_ready[id] = 1'b1;
    @(negedge clk);
    rsp_ready[id] = 1'b0;
    chk("job_idle_after", busy, 0);
  endtask

  typedef struct {
    int            id;
    logic [OW-1:0] op;
    logic [DW-1:0] a, b;
    int            lat;
    logic [DW-1:0] exp_data;
    int            exp_lat;
  } vec_t;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t vecs [5];
    int rlat, w;
    logic [DW-1:0] d, d0;
    logic e;
    logic [1:0] fair_exp [4];
    logic m_busy, m_resp, m_start_due, m_last;
    int m_w, jobs_done;
    logic [DW-1:0] m_exp;
    logic [1:0] exp_rdy, accepted;

    vecs[0] = '{0, 4'd1, 32'd10,          32'd20,     2, 32'd30,     4};
    vecs[1] = '{1, 4'd2, 32'd100,         32'd30,     1, 32'd70,     3};
    vecs[2] = '{0, 4'd3, 32'd7,           32'd6,      5, 32'd42,     7};
    vecs[3] = '{1, 4'd1, 32'hFFFF_FFFF,   32'd1,      3, 32'd0,      5};
    vecs[4] = '{0, 4'd4, 32'h0000_F0F0,   32'h0FF0,   1, 32'hFF00,   3};
    fair_exp = '{2'b01, 2'b10, 2'b01, 2'b10};

    reset = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00; stray_done = 1'b0;
    for (int i = 0; i < 2; i++) begin r_op[i] = '0; r_a[i] = '0; r_b[i] = '0; end
    drive_req();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_fpu_start", fpu_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_fpu_op", fpu_op, 0);
    chk("rst_fpu_a", fpu_a, 0);
    chk("rst_fpu_b", fpu_b, 0);
    reset = 1'b1;

    // Table of single jobs
    for (int i = 0; i < 5; i++) begin
      run_job(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, rlat, d, e);
      chk("tbl_latency", rlat, vecs[i].exp_lat);
      chk("tbl_data", d, vecs[i].exp_data);
      chk("tbl_err", e, 0);
    end

    // A done pulse while idle must not start anything
    @(negedge clk);
    pulse_stray();
    chk("idle_done_busy", busy, 0);
    chk("idle_done_rsp", rsp_valid, 0);

    // Contention after reset, with back-pressure on requester 0's result
    do_reset();
    fpu_lat = 2;
    r_op[0] = FPU_OP_ADD; r_a[0] = 32'd3; r_b[0] = 32'd4;
    r_op[1] = FPU_OP_MUL; r_a[1] = 32'd5; r_b[1] = 32'd6;
    drive_req();
    req_valid = 2'b11;
    #1;
    chk("cont_first_grant", req_ready, 2'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    rsp_ready = 2'b10;
    chk("cont_start", fpu_start, 1);
    w = 0;
    while (rsp_valid == 2'b00 && w < 50) begin
      #1; chk("cont_busy_no_ready", req_ready, 0);
      @(negedge clk); w++;
    end
    d0 = rsp_data;
    chk("cont_rsp0_data", d0, 32'd7);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_rsp_valid", rsp_valid, 2'b01);
      chk("bp_rsp_data", rsp_data, 32'd7);
      chk("bp_req_ready1", req_ready, 2'b00);
      @(negedge clk);
    end
    rsp_ready = 2'b01;
    #1;
    chk("bp_accept_cycle_ready", req_ready, 2'b00);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1;
    chk("cont_second_grant", req_ready, 2'b10);
    @(negedge clk);
    req_valid[1] = 1'b0;
    chk("cont_grant_id", grant_id, 1);
    run_wait: begin
      w = 0;
      while (rsp_valid == 2'b00 && w < 50) begin @(negedge clk); w++; end
    end
    chk("cont_rsp1_valid", rsp_valid, 2'b10);
    chk("cont_rsp1_data", rsp_data, 32'd30);
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;

    // Fairness: both always requesting, results accepted at once
    fpu_lat = 1;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    for (int j = 0; j < 4; j++) begin
      #1;
      w = 0;
      while (req_ready == 2'b00 && w < 50) begin @(negedge clk); #1; w++; end
      chk("fair_grant", req_ready, fair_exp[j]);
      @(negedge clk);
    end
    req_valid = 2'b00;
    w = 0;
    while (busy && w < 50) begin @(negedge clk); w++; end
    chk("fair_drain", busy, 0);
    rsp_ready = 2'b00;

    // Reset in the middle of WAIT
    fpu_lat = 0;
    r_op[0] = FPU_OP_SUB; r_a[0] = 32'd9; r_b[0] = 32'd2;
    drive_req();
    req_valid = 2'b01;
    #1;
    chk("rw_ready", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("rw_in_wait", busy, 1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("rw_busy", busy, 0);
    chk("rw_rsp_valid", rsp_valid, 0);
    chk("rw_job_a", fpu_a, 0);
    pulse_stray();
    for (int k = 0; k < 3; k++) begin
      chk("rw_late_done_rsp", rsp_valid, 0);
      chk("rw_late_done_busy", busy, 0);
      @(negedge clk);
    end

`ifdef FPU_TIMEOUT_EN
    // FPU never answers: abort exactly TIMEOUT cycles after entering WAIT
    fpu_lat = 0;
    r_op[0] = FPU_OP_ADD; r_a[0] = 32'd1; r_b[0] = 32'd2;
    drive_req();
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    rlat = 1;
    while (rsp_valid == 2'b00 && rlat < 100) begin @(negedge clk); rlat++; end
    chk("to_latency", rlat, TO + 2);
    chk("to_err", rsp_err, 1);
    chk("to_data", rsp_data, 0);
    pulse_stray();
    chk("to_stray_valid", rsp_valid, 2'b01);
    chk("to_stray_err", rsp_err, 1);
    chk("to_stray_data", rsp_data, 0);
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
    // done on the very expiry cycle wins
    run_job(1, FPU_OP_SUB, 32'd50, 32'd8, TO, rlat, d, e);
    chk("to_race_latency", rlat, TO + 2);
    chk("to_race_err", e, 0);
    chk("to_race_data", d, 32'd42);
`endif

    // Randomized run against a transaction-level model
    do_reset();
    m_busy = 1'b0; m_resp = 1'b0; m_start_due = 1'b0; m_last = 1'b1;
    m_w = 0; m_exp = '0; jobs_done = 0; accepted = 2'b00;
    repeat (600) begin
      @(negedge clk);
      if (m_busy) begin
        chk("rnd_busy", busy, 1);
        chk("rnd_start", fpu_start, m_start_due);
        m_start_due = 1'b0;
        if (m_resp) begin
          chk("rnd_rsp_valid", rsp_valid, 2'b01 << m_w);
          chk("rnd_rsp_data", rsp_data, m_exp);
          chk("rnd_rsp_err", rsp_err, 0);
        end else begin
          chk("rnd_rsp_early", rsp_valid, 0);
        end
      end else begin
        chk("rnd_idle_busy", busy, 0);
        chk("rnd_idle_rsp", rsp_valid, 0);
        chk("rnd_idle_start", fpu_start, 0);
      end
      for (int i = 0; i < 2; i++) begin
        if (accepted[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          r_op[i] = OW'($urandom_range(1, 4));
          r_a[i]  = $urandom;
          r_b[i]  = $urandom_range(0, 5000);
          req_valid[i] = 1'b1;
        end
      end
      accepted = 2'b00;
      drive_req();
      rsp_ready = 2'($urandom_range(0, 3));
      fpu_lat = $urandom_range(1, 6);
      #1;
      if (!m_busy) begin
        if (req_valid == 2'b11) exp_rdy = (m_last == 1'b1) ? 2'b01 : 2'b10;
        else                    exp_rdy = req_valid;
        chk("rnd_req_ready", req_ready, exp_rdy);
        if (exp_rdy != 2'b00) begin
          m_w = (exp_rdy == 2'b10) ? 1 : 0;
          m_exp = fpu_fn(r_op[m_w], r_a[m_w], r_b[m_w]);
          m_busy = 1'b1; m_resp = 1'b0; m_start_due = 1'b1;
          accepted[m_w] = 1'b1;
        end
      end else begin
        chk("rnd_no_ready", req_ready, 0);
        if (m_resp) begin
          if (rsp_ready[m_w]) begin
            m_busy = 1'b0;
            m_last = (m_w == 1);
            jobs_done++;
          end
        end else if (fpu_done) begin
          m_resp = 1'b1;
        end
      end
    end
    chk("rnd_progress", (jobs_done > 20), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_job_scheduler.md
# fpu_job_scheduler

Shares the single FPU core between two requesters (host-side bus bridge on port 0, on-chip sequencer on port 1). Each request is one job: an opcode and two 32-bit operands. Requests are granted round-robin, and only one job is in flight at a time. The block pulses the FPU start, waits for its variable-latency done, then returns the result to the granted requester over a valid/ready response channel. It sits between the memory-mapped FPU register window (A/B/CMD/RESULT) and the FPU datapath.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- OP_W, 4, opcode width (CMD register low bits; 1 = add)
- TIMEOUT, 64, max WAIT cycles before abort (used only with FPU_TIMEOUT_EN)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-low
- req_valid  input  2  per-requester job request
- req_ready  output  2  per-requester accept; one-hot or zero
- req_op  input  2*OP_W  opcodes; requester i at [i*OP_W +: OP_W]
- req_a, req_b  input  2*DATA_W  operands, packed the same way
- rsp_valid  output  2  per-requester result valid; one-hot or zero
- rsp_ready  input  2  per-requester result accept
- rsp_data  output  DATA_W  result, shared by both requesters
- rsp_err  output  1  job aborted (timeout)
- fpu_start  output  1  one-cycle job start pulse
- fpu_op  output  OP_W  opcode to FPU
- fpu_a, fpu_b  output  DATA_W  operands to FPU
- fpu_done  input  1  FPU result valid (single-cycle pulse)
- fpu_result  input  DATA_W  FPU result
- busy  output  1  high in every state except IDLE
- grant_id  output  1  index of the requester currently or last granted

## Operation
The controller is a four-state FSM: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Winner among req_valid is chosen by round-robin against last_grant.
  - If both requesters are valid, the one not equal to last_grant wins. A single valid requester always wins.
  - req_ready[winner] is driven combinationally high in IDLE only.
  - On handshake: latch op/a/b into job registers, set grant_id, go to ISSUE.
  - A requester may drop req_valid before the handshake without effect.
- **ISSUE**: fpu_start=1 for exactly one cycle; go to WAIT.
- **WAIT**
  - On fpu_done: latch fpu_result into rsp_data, set rsp_err=0, go to RESP.
  - fpu_done is honoured only in WAIT; it is ignored in all other states.
- **RESP**
  - rsp_valid[grant_id] is held high, with rsp_data and rsp_err stable.
  - On rsp_ready[grant_id]: set last_grant=grant_id, go to IDLE.
  - rsp_ready of the non-granted requester is ignored.
  - No new grant is made while in RESP, so back-pressure stalls both requesters.
- fpu_op/fpu_a/fpu_b are driven from the job registers and stay stable from ISSUE through RESP.
- Result width equals DATA_W; there is no truncation or extension.

## Timing
- Reset values:
  - State and outputs: state=IDLE, busy=0, grant_id=0, fpu_start=0, rsp_valid=0, rsp_err=0, rsp_data=0.
  - Job registers: fpu_op/a/b=0.
  - Arbiter: last_grant=1, so requester 0 wins the first contention.
- Job pipeline, with the request handshake in cycle N:
  - N+1: fpu_start high.
  - N+2: earliest cycle fpu_done is honoured.
  - Done honoured in cycle M → rsp_valid high from cycle M+1.
  - Minimum request-to-response latency is 3 cycles.
- Response to next accept:
  - Response handshake in cycle R → IDLE in R+1.
  - Earliest next req_ready is R+1.
- Reset asserted mid-job (any state): the job is dropped with no response, and the block returns to IDLE. A late fpu_done after reset is ignored.

## Configuration
- **FPU_TIMEOUT_EN defined**
  - An 8-bit cycle counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT-1 without fpu_done, the block goes to RESP with rsp_err=1 and rsp_data=0.
  - fpu_done arriving in the same cycle as expiry wins: normal result, rsp_err=0.
- **FPU_TIMEOUT_EN undefined**
  - WAIT lasts until fpu_done, with no bound.
  - rsp_err is tied 0, and no counter logic exists.

## Structure
- Package fpu_sched_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - the opcode constants (FPU_OP_ADD=1, SUB=2, MUL=3);
  - the DATA_W/OP_W defaults.
- Sub-module rr_arbiter2 contains the two-input round-robin grant logic (inputs: req[1:0], last; output: one-hot grant).

## Test plan
- **Single add:** requester 0 submits op=1, a=10, b=20; the FPU model asserts done 2 cycles after start → rsp_valid[0] at handshake+4, rsp_data=30, rsp_err=0.
- **Contention:** both requesters are valid with last_grant=1 → requester 0 served first; requester 1 is accepted the cycle after requester 0's response handshake; grant_id=1.
- **Back-pressure:** rsp_ready[0] is held low 5 cycles → rsp_valid[0] and rsp_data stay stable; req_ready[1] stays 0 throughout.
- **Timeout (FPU_TIMEOUT_EN, TIMEOUT=8):** the FPU never signals done → rsp_err=1 and rsp_data=0 exactly 8 cycles after entering WAIT; a later stray fpu_done is ignored.
- **Reset mid-WAIT:** reset is pulled low for 1 cycle → next cycle busy=0 and all rsp_valid=0; a subsequent done pulse produces no response.
- **Fairness:** both requesters are continuously valid for 4 jobs → grants alternate 0,1,0,1.
